// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Stall/flush responder for the 5-stage core. Drives latch
//               enables, bubble/flush controls and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             md_ready,
    input  logic             mem_hold,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             xm_bubble,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                c_wait_w    = $clog2(MD_TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_WAIT = 2'b01
    } state_t;

    state_t              state_q, state_d;
    logic [c_wait_w-1:0] wait_q, wait_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                w_flush_evt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        w_flush_evt = 1'b0;
        pc_en       = 1'b1;
        fd_en       = 1'b1;
        dx_en       = 1'b1;
        xm_en       = 1'b1;
        mw_en       = 1'b1;
        fd_flush    = 1'b0;
        dx_bubble   = 1'b0;
        xm_bubble   = 1'b0;

        // Outputs read as RUN-idle while reset is asserted.
        if (!reset_n) begin
            state_d = ST_RUN;
        end else if (mem_hold) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            dx_en = 1'b0;
            xm_en = 1'b0;
            mw_en = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (md_start) begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_en     = 1'b0;
                        xm_bubble = 1'b1;
                        state_d   = ST_MD_WAIT;
                        wait_d    = '0;
                    end else if (branch_taken) begin
                        fd_flush    = 1'b1;
                        dx_bubble   = 1'b1;
                        w_flush_evt = 1'b1;
                    end else if (stall_req) begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_bubble = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    if (md_ready) begin
                        state_d = ST_RUN;
                        wait_d  = '0;
                    end else begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_en     = 1'b0;
                        xm_bubble = 1'b1;
                        // Abandon the op; it drains as a bubble.
                        if (wait_q == c_wait_last) begin
                            timeout_d = 1'b1;
                            state_d   = ST_RUN;
                            wait_d    = '0;
                        end else begin
                            wait_d = wait_q + c_wait_w'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_en && stall_cnt_q != c_cnt_max)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (w_flush_evt && flush_cnt_q != c_cnt_max)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign md_busy    = reset_n && (state_q == ST_MD_WAIT);
    assign md_timeout = timeout_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Directed bench for pipe_stall_ctrl, default and small configs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;

    logic clock = 1'b0;
    logic reset_n, stall_req, branch_taken, md_start, md_ready, mem_hold;

    logic pc_en_b, fd_en_b, dx_en_b, xm_en_b, mw_en_b, fd_flush_b, dx_bubble_b, xm_bubble_b;
    logic md_busy_b, md_timeout_b;
    logic [15:0] stall_cnt_b, flush_cnt_b;
    logic pc_en_s, fd_en_s, dx_en_s, xm_en_s, mw_en_s, fd_flush_s, dx_bubble_s, xm_bubble_s;
    logic md_busy_s, md_timeout_s;
    logic [3:0] stall_cnt_s, flush_cnt_s;

    logic [7:0] w_ctrl_b, w_ctrl_s;
    assign w_ctrl_b = {pc_en_b, fd_en_b, dx_en_b, xm_en_b, mw_en_b, fd_flush_b, dx_bubble_b, xm_bubble_b};
    assign w_ctrl_s = {pc_en_s, fd_en_s, dx_en_s, xm_en_s, mw_en_s, fd_flush_s, dx_bubble_s, xm_bubble_s};

    // {pc, fd, dx, xm, mw enables, fd_flush, dx_bubble, xm_bubble}
    localparam logic [7:0] c_idle   = 8'b11111_000;
    localparam logic [7:0] c_stall  = 8'b00111_010;
    localparam logic [7:0] c_branch = 8'b11111_110;
    localparam logic [7:0] c_mdwait = 8'b00011_001;
    localparam logic [7:0] c_hold   = 8'b00000_000;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pipe_stall_ctrl u_big (
        .clock(clock), .reset_n(reset_n), .stall_req(stall_req), .branch_taken(branch_taken),
        .md_start(md_start), .md_ready(md_ready), .mem_hold(mem_hold),
        .pc_en(pc_en_b), .fd_en(fd_en_b), .dx_en(dx_en_b), .xm_en(xm_en_b), .mw_en(mw_en_b),
        .fd_flush(fd_flush_b), .dx_bubble(dx_bubble_b), .xm_bubble(xm_bubble_b),
        .md_busy(md_busy_b), .md_timeout(md_timeout_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    pipe_stall_ctrl #(.MD_TIMEOUT(4), .CNT_W(4)) u_small (
        .clock(clock), .reset_n(reset_n), .stall_req(stall_req), .branch_taken(branch_taken),
        .md_start(md_start), .md_ready(md_ready), .mem_hold(mem_hold),
        .pc_en(pc_en_s), .fd_en(fd_en_s), .dx_en(dx_en_s), .xm_en(xm_en_s), .mw_en(mw_en_s),
        .fd_flush(fd_flush_s), .dx_bubble(dx_bubble_s), .xm_bubble(xm_bubble_s),
        .md_busy(md_busy_s), .md_timeout(md_timeout_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic br, input logic ms, input logic mr, input logic mh);
        stall_req = st; branch_taken = br; md_start = ms; md_ready = mr; mem_hold = mh;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1, 1, 1, 0, 0);
        n_vec++; if (w_ctrl_b !== c_idle) begin n_err++; $display("FAIL reset_ctrl got=%b exp=%b", w_ctrl_b, c_idle); end
        n_vec++; if (md_busy_b !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", md_busy_b); end
        tick();
        tick();
        n_vec++; if (stall_cnt_b !== 16'd0 || flush_cnt_b !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt_b, flush_cnt_b); end
        n_vec++; if (md_timeout_b !== 1'b0 || md_busy_b !== 1'b0) begin n_err++; $display("FAIL reset_md got=%b%b exp=00", md_timeout_b, md_busy_b); end
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        n_vec++; if (w_ctrl_b !== c_idle) begin n_err++; $display("FAIL idle_ctrl got=%b exp=%b", w_ctrl_b, c_idle); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0);
        n_vec++; if (w_ctrl_b !== c_stall) begin n_err++; $display("FAIL load_use_ctrl got=%b exp=%b", w_ctrl_b, c_stall); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_vec++; if (stall_cnt_b !== 16'd1) begin n_err++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt_b); end
        n_vec++; if (w_ctrl_b !== c_idle) begin n_err++; $display("FAIL load_use_after got=%b exp=%b", w_ctrl_b, c_idle); end
    endtask

    task automatic test_branch_stall();
        drive(1, 1, 0, 0, 0);
        n_vec++; if (w_ctrl_b !== c_branch) begin n_err++; $display("FAIL branch_ctrl got=%b exp=%b", w_ctrl_b, c_branch); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_vec++; if (flush_cnt_b !== 16'd1) begin n_err++; $display("FAIL branch_flush_cnt got=%0d exp=1", flush_cnt_b); end
        n_vec++; if (stall_cnt_b !== 16'd1) begin n_err++; $display("FAIL branch_stall_cnt got=%0d exp=1", stall_cnt_b); end
    endtask

    task automatic test_md_ready();
        do_reset();
        drive(0, 0, 1, 0, 0);
        n_vec++; if (w_ctrl_b !== c_mdwait || md_busy_b !== 1'b0) begin n_err++; $display("FAIL md_start got=%b/%b exp=%b/0", w_ctrl_b, md_busy_b, c_mdwait); end
        tick();
        for (int i = 0; i < 5; i++) begin
            // hazards and redirects must be ignored while waiting
            drive(1, 1, 1, 0, 0);
            n_vec++; if (w_ctrl_b !== c_mdwait || md_busy_b !== 1'b1) begin n_err++; $display("FAIL md_wait%0d got=%b/%b exp=%b/1", i, w_ctrl_b, md_busy_b, c_mdwait); end
            tick();
        end
        drive(0, 0, 0, 1, 0);
        n_vec++; if (w_ctrl_b !== c_idle || md_busy_b !== 1'b1) begin n_err++; $display("FAIL md_ready got=%b/%b exp=%b/1", w_ctrl_b, md_busy_b, c_idle); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_vec++; if (md_busy_b !== 1'b0 || md_timeout_b !== 1'b0) begin n_err++; $display("FAIL md_done got=%b%b exp=00", md_busy_b, md_timeout_b); end
        n_vec++; if (stall_cnt_b !== 16'd6 || flush_cnt_b !== 16'd0) begin n_err++; $display("FAIL md_cnts got=%0d/%0d exp=6/0", stall_cnt_b, flush_cnt_b); end
    endtask

    task automatic test_timeout();
        do_reset();
        // ready on the last allowed cycle wins over the timeout
        drive(0, 0, 1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 0);
        n_vec++; if (w_ctrl_s !== c_idle) begin n_err++; $display("FAIL to_ready_ctrl got=%b exp=%b", w_ctrl_s, c_idle); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_vec++; if (md_timeout_s !== 1'b0 || md_busy_s !== 1'b0) begin n_err++; $display("FAIL to_ready_wins got=%b%b exp=00", md_timeout_s, md_busy_s); end
        drive(0, 0, 1, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0);
            n_vec++; if (w_ctrl_s !== c_mdwait || md_busy_s !== 1'b1) begin n_err++; $display("FAIL to_wait%0d got=%b/%b exp=%b/1", i, w_ctrl_s, md_busy_s, c_mdwait); end
            tick();
        end
        n_vec++; if (md_timeout_s !== 1'b1 || md_busy_s !== 1'b0) begin n_err++; $display("FAIL to_expire got=%b%b exp=10", md_timeout_s, md_busy_s); end
        n_vec++; if (w_ctrl_s !== c_idle) begin n_err++; $display("FAIL to_run_ctrl got=%b exp=%b", w_ctrl_s, c_idle); end
        n_vec++; if (md_busy_b !== 1'b1 || md_timeout_b !== 1'b0) begin n_err++; $display("FAIL to_big_waiting got=%b%b exp=10", md_busy_b, md_timeout_b); end
    endtask

    task automatic test_mem_hold();
        do_reset();
        drive(0, 0, 1, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 1);
            n_vec++; if (w_ctrl_s !== c_hold || md_busy_s !== 1'b1) begin n_err++; $display("FAIL hold%0d got=%b/%b exp=%b/1", i, w_ctrl_s, md_busy_s, c_hold); end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        n_vec++; if (stall_cnt_s !== 4'd6 || md_busy_s !== 1'b1) begin n_err++; $display("FAIL hold_cnt got=%0d/%b exp=6/1", stall_cnt_s, md_busy_s); end
        tick();
        n_vec++; if (md_busy_s !== 1'b1 || md_timeout_s !== 1'b0) begin n_err++; $display("FAIL hold_frozen got=%b%b exp=10", md_busy_s, md_timeout_s); end
        tick();
        n_vec++; if (md_busy_s !== 1'b0 || md_timeout_s !== 1'b1) begin n_err++; $display("FAIL hold_resume got=%b%b exp=01", md_busy_s, md_timeout_s); end
        n_vec++; if (stall_cnt_b !== 16'd8) begin n_err++; $display("FAIL hold_stall_b got=%0d exp=8", stall_cnt_b); end
        drive(0, 1, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        n_vec++; if (flush_cnt_s !== 4'd0 || stall_cnt_s !== 4'd9) begin n_err++; $display("FAIL hold_branch got=%0d/%0d exp=0/9", flush_cnt_s, stall_cnt_s); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0);
            tick();
        end
        n_vec++; if (stall_cnt_s !== 4'd15 || stall_cnt_b !== 16'd20) begin n_err++; $display("FAIL sat_stall got=%0d/%0d exp=15/20", stall_cnt_s, stall_cnt_b); end
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 0, 0);
            tick();
        end
        n_vec++; if (flush_cnt_s !== 4'd15 || flush_cnt_b !== 16'd20) begin n_err++; $display("FAIL sat_flush got=%0d/%0d exp=15/20", flush_cnt_s, flush_cnt_b); end
        n_vec++; if (stall_cnt_s !== 4'd15) begin n_err++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt_s); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b0;
        drive(1, 1, 1, 0, 0);
        n_vec++; if (w_ctrl_b !== c_idle || md_busy_b !== 1'b0) begin n_err++; $display("FAIL rmw_ctrl got=%b/%b exp=%b/0", w_ctrl_b, md_busy_b, c_idle); end
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        n_vec++; if (stall_cnt_b !== 16'd0 || stall_cnt_s !== 4'd0 || flush_cnt_b !== 16'd0) begin n_err++; $display("FAIL rmw_cnt got=%0d/%0d/%0d exp=0/0/0", stall_cnt_b, stall_cnt_s, flush_cnt_b); end
        n_vec++; if (md_busy_b !== 1'b0 || w_ctrl_b !== c_idle) begin n_err++; $display("FAIL rmw_run got=%b/%b exp=0/%b", md_busy_b, w_ctrl_b, c_idle); end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_branch_stall();
        test_md_ready();
        test_timeout();
        test_mem_hold();
        test_saturate();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
